// File: rtl/unidad_control_multiciclo.sv
// rtl/unidad_control_multiciclo.sv - main control FSM for the multicycle MIPS datapath
module unidad_control_multiciclo #(
  parameter logic [5:0] OP_RTYPE = 6'b000000,
  parameter logic [5:0] OP_LW    = 6'b100011,
  parameter logic [5:0] OP_SW    = 6'b101011,
  parameter logic [5:0] OP_BEQ   = 6'b000100,
  parameter logic [5:0] OP_J     = 6'b000010,
  parameter logic [5:0] OP_ADDI  = 6'b001000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_listo,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       ALUSrcA,
  output logic [1:0] PCSource,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [3:0] estado,
  output logic       opcode_invalido
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE   = 4'd6,
    S_R_COMPL   = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EXEC = 4'd10,
    S_ADDI_WB   = 4'd11
  } estado_t;

  estado_t estado_q, estado_d;

  always_ff @(posedge clk) begin
    if (reset) estado_q <= S_FETCH;
    else       estado_q <= estado_d;
  end

  always_comb begin
    estado_d        = estado_q;
    PCWrite         = 1'b0;
    PCWriteCond     = 1'b0;
    IorD            = 1'b0;
    MemRead         = 1'b0;
    MemWrite        = 1'b0;
    IRWrite         = 1'b0;
    MemtoReg        = 1'b0;
    RegWrite        = 1'b0;
    RegDst          = 1'b0;
    ALUSrcA         = 1'b0;
    PCSource        = 2'b00;
    ALUSrcB         = 2'b00;
    ALUOp           = 2'b00;
    opcode_invalido = 1'b0;
    estado          = estado_q;

    case (estado_q)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_listo;
        PCWrite = mem_listo;
        if (mem_listo) estado_d = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        if (opcode == OP_LW || opcode == OP_SW) estado_d = S_MEM_ADDR;
        else if (opcode == OP_RTYPE)            estado_d = S_EXECUTE;
        else if (opcode == OP_BEQ)              estado_d = S_BRANCH;
        else if (opcode == OP_J)                estado_d = S_JUMP;
        else if (opcode == OP_ADDI)             estado_d = S_ADDI_EXEC;
        else begin
          estado_d        = S_FETCH;
          opcode_invalido = 1'b1;
        end
      end
      S_MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        // IR still holds the instruction, so the opcode picks load vs store
        if (opcode == OP_SW)      estado_d = S_MEM_WRITE;
        else if (opcode == OP_LW) estado_d = S_MEM_READ;
        else                      estado_d = S_FETCH;
      end
      S_MEM_READ: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (mem_listo) estado_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
        estado_d = S_FETCH;
      end
      S_MEM_WRITE: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        if (mem_listo) estado_d = S_FETCH;
      end
      S_EXECUTE: begin
        ALUSrcA  = 1'b1;
        ALUOp    = 2'b10;
        estado_d = S_R_COMPL;
      end
      S_R_COMPL: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
        estado_d = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        estado_d    = S_FETCH;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
        estado_d = S_FETCH;
      end
      S_ADDI_EXEC: begin
        ALUSrcA  = 1'b1;
        ALUSrcB  = 2'b10;
        estado_d = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        RegWrite = 1'b1;
        estado_d = S_FETCH;
      end
      default: estado_d = S_FETCH;
    endcase

    // Reset silences the datapath in the very cycle it is asserted
    if (reset) begin
      PCWrite         = 1'b0;
      PCWriteCond     = 1'b0;
      IorD            = 1'b0;
      MemRead         = 1'b0;
      MemWrite        = 1'b0;
      IRWrite         = 1'b0;
      MemtoReg        = 1'b0;
      RegWrite        = 1'b0;
      RegDst          = 1'b0;
      ALUSrcA         = 1'b0;
      PCSource        = 2'b00;
      ALUSrcB         = 2'b00;
      ALUOp           = 2'b00;
      opcode_invalido = 1'b0;
      estado          = 4'd0;
    end
  end

endmodule

// File: tb/tb_unidad_control_multiciclo.sv
// tb/tb_unidad_control_multiciclo.sv - scoreboard bench for the multicycle control FSM
module tb_unidad_control_multiciclo;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       mem_listo;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegWrite, RegDst, ALUSrcA;
  logic [1:0] PCSource, ALUSrcB, ALUOp;
  logic [3:0] estado;
  logic       opcode_invalido;

  int checks = 0;
  int errors = 0;
  int irwrite_cnt;
  int bad_cnt;

  logic [20:0] exp_q[$];

  unidad_control_multiciclo dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_listo(mem_listo),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .RegDst(RegDst),
    .ALUSrcA(ALUSrcA), .PCSource(PCSource), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .estado(estado), .opcode_invalido(opcode_invalido)
  );

  always #5 clk = ~clk;

  // Expected control word from the state table:
  // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegWrite,RegDst,ALUSrcA,PCSource,ALUSrcB,ALUOp,inv}
  function automatic logic [16:0] exp_outs(logic [3:0] st, logic ml, logic [5:0] op, logic rst);
    logic pcw, pcc, iod, mr, mw, irw, m2r, rw, rd, asa, inv;
    logic [1:0] pcs, asb, aop;
    {pcw, pcc, iod, mr, mw, irw, m2r, rw, rd, asa, inv} = '0;
    pcs = 2'b00; asb = 2'b00; aop = 2'b00;
    case (st)
      4'd0:  begin mr = 1; asb = 2'b01; irw = ml; pcw = ml; end
      4'd1:  begin asb = 2'b11;
               inv = !(op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000}); end
      4'd2:  begin asa = 1; asb = 2'b10; end
      4'd3:  begin mr = 1; iod = 1; end
      4'd4:  begin rw = 1; m2r = 1; end
      4'd5:  begin mw = 1; iod = 1; end
      4'd6:  begin asa = 1; aop = 2'b10; end
      4'd7:  begin rw = 1; rd = 1; end
      4'd8:  begin asa = 1; aop = 2'b01; pcc = 1; pcs = 2'b01; end
      4'd9:  begin pcw = 1; pcs = 2'b10; end
      4'd10: begin asa = 1; asb = 2'b10; end
      4'd11: begin rw = 1; end
      default: ;
    endcase
    if (rst) return 17'd0;
    return {pcw, pcc, iod, mr, mw, irw, m2r, rw, rd, asa, pcs, asb, aop, inv};
  endfunction

  // One cycle: drive inputs after the falling edge, push expectation, sample 1ns later.
  task automatic step(input logic rst, input logic ml, input logic [5:0] op, input logic [3:0] exp_st);
    logic [20:0] got, want;
    @(negedge clk);
    reset = rst; mem_listo = ml; opcode = op;
    exp_q.push_back({(rst ? 4'd0 : exp_st), exp_outs(exp_st, ml, op, rst)});
    #1;
    got = {estado, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
           RegWrite, RegDst, ALUSrcA, PCSource, ALUSrcB, ALUOp, opcode_invalido};
    want = exp_q.pop_front();
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL step op=%b st=%0d: got estado=%0d ctl=%b, expected estado=%0d ctl=%b",
               op, exp_st, got[20:17], got[16:0], want[20:17], want[16:0]);
    end
    checks++;
    if ((MemRead && MemWrite) || (RegWrite && PCWrite)) begin
      errors++;
      $display("FAIL exclusivity: MemRead=%b MemWrite=%b RegWrite=%b PCWrite=%b, expected no overlap",
               MemRead, MemWrite, RegWrite, PCWrite);
    end
    if (IRWrite === 1'b1) irwrite_cnt++;
    if (RegWrite === 1'b1 || (MemWrite === 1'b1 && ml)) bad_cnt++;
  endtask

  task automatic do_reset();
    step(1'b1, 1'b1, 6'd0, 4'd0);
  endtask

  task automatic test_reset();
    repeat (3) step(1'b1, 1'b1, 6'b000000, 4'd0);
    step(1'b0, 1'b1, 6'b000000, 4'd0);
  endtask

  task automatic test_rtype();
    do_reset();
    step(0, 1, 6'b000000, 4'd0);
    step(0, 1, 6'b000000, 4'd1);
    step(0, 1, 6'b000000, 4'd6);
    step(0, 1, 6'b000000, 4'd7);
    step(0, 1, 6'b000000, 4'd0);
  endtask

  task automatic test_lw_wait();
    logic [5:0] op = 6'b100011;
    do_reset();
    irwrite_cnt = 0;
    step(0, 0, op, 4'd0);
    step(0, 0, op, 4'd0);
    step(0, 1, op, 4'd0);
    step(0, 1, op, 4'd1);
    step(0, 1, op, 4'd2);
    step(0, 0, op, 4'd3);
    step(0, 0, op, 4'd3);
    step(0, 1, op, 4'd3);
    step(0, 1, op, 4'd4);
    step(0, 0, op, 4'd0);
    checks++;
    if (irwrite_cnt != 1) begin
      errors++;
      $display("FAIL lw_irwrite_pulses: got %0d, expected 1", irwrite_cnt);
    end
  endtask

  task automatic test_sw();
    do_reset();
    step(0, 1, 6'b101011, 4'd0);
    step(0, 1, 6'b101011, 4'd1);
    step(0, 1, 6'b101011, 4'd2);
    step(0, 1, 6'b101011, 4'd5);
    step(0, 1, 6'b101011, 4'd0);
  endtask

  task automatic test_branch_jump();
    do_reset();
    step(0, 1, 6'b000100, 4'd0);
    step(0, 1, 6'b000100, 4'd1);
    step(0, 1, 6'b000100, 4'd8);
    step(0, 1, 6'b000010, 4'd0);
    step(0, 1, 6'b000010, 4'd1);
    step(0, 1, 6'b000010, 4'd9);
    step(0, 1, 6'b001000, 4'd0);
    step(0, 1, 6'b001000, 4'd1);
    step(0, 1, 6'b001000, 4'd10);
    step(0, 1, 6'b001000, 4'd11);
    step(0, 1, 6'b001000, 4'd0);
  endtask

  task automatic test_illegal();
    do_reset();
    bad_cnt = 0;
    step(0, 1, 6'b111111, 4'd0);
    step(0, 1, 6'b111111, 4'd1);
    step(0, 0, 6'b111111, 4'd0);
    checks++;
    if (bad_cnt != 0) begin
      errors++;
      $display("FAIL illegal_no_write: got %0d write cycles, expected 0", bad_cnt);
    end
  endtask

  task automatic test_reset_mid_store();
    logic [5:0] op = 6'b101011;
    do_reset();
    step(0, 1, op, 4'd0);
    step(0, 1, op, 4'd1);
    step(0, 1, op, 4'd2);
    bad_cnt = 0;
    step(0, 0, op, 4'd5);
    step(0, 0, op, 4'd5);
    step(1, 0, op, 4'd5);
    step(0, 1, op, 4'd0);
    checks++;
    if (bad_cnt != 0) begin
      errors++;
      $display("FAIL reset_store_completed: got %0d completing cycles, expected 0", bad_cnt);
    end
  endtask

  initial begin
    reset = 1'b1; mem_listo = 1'b1; opcode = 6'd0;
    irwrite_cnt = 0; bad_cnt = 0;
    test_reset();
    test_rtype();
    test_lw_wait();
    test_sw();
    test_branch_jump();
    test_illegal();
    test_reset_mid_store();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/unidad_control_multiciclo.md
Name: unidad_control_multiciclo

Overview:
Main control FSM for the multicycle MIPS datapath. It is the producer side of the ALUOp interface: it decodes the 6-bit opcode and drives ALUOp[1:0] to the ALU control decoder, which then turns ALUOp plus funct into the ALU operation code. It also sequences every datapath enable (PC, IR, memory, register file, muxes) across fetch, decode, execute, memory and write-back. A memory-ready handshake allows multi-cycle memory accesses.

Parameters:
OP_RTYPE, 6'b000000, R-type opcode
OP_LW, 6'b100011, load word
OP_SW, 6'b101011, store word
OP_BEQ, 6'b000100, branch if equal
OP_J, 6'b000010, jump
OP_ADDI, 6'b001000, add immediate

Ports:
clk  input  1  single clock; all state updates on rising edge
reset  input  1  synchronous, active-high
opcode  input  6  instr[31:26] from IR, sampled in DECODE
mem_listo  input  1  memory ready; access completes in a cycle where it is 1
PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegWrite, RegDst, ALUSrcA  output  1 each  datapath controls
PCSource  output  2  00 ALU result, 01 ALUOut, 10 jump target
ALUSrcB  output  2  00 regB, 01 constant 4, 10 sign-ext imm, 11 sign-ext imm<<2
ALUOp  output  2  00 add, 01 subtract (beq), 10 use funct
estado  output  4  current state, for debug
opcode_invalido  output  1  high in DECODE when the opcode is unsupported

Behaviour:
- Moore FSM. Outputs are a combinational decode of the state register, except that IRWrite and PCWrite in FETCH are gated by mem_listo.
- State encoding: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXECUTE=6, R_COMPL=7, BRANCH=8, JUMP=9, ADDI_EXEC=10, ADDI_WB=11.
- Reset: while reset=1, every output is 0. On the next edge the state becomes FETCH (estado=0). Reset mid-instruction abandons the instruction immediately; no partial write occurs after the reset edge.
- Any output not listed for a state is 0 in that state.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00, IRWrite=PCWrite=mem_listo. Stay in FETCH while mem_listo=0; go to DECODE when mem_listo=1.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00.
  - lw or sw -> MEM_ADDR
  - R-type -> EXECUTE
  - beq -> BRANCH
  - j -> JUMP
  - addi -> ADDI_EXEC
  - any other opcode -> FETCH with opcode_invalido=1 for this one cycle
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next state is MEM_READ for lw, MEM_WRITE for sw, using the opcode held in IR.
- MEM_READ: MemRead=1, IorD=1. Hold until mem_listo=1, then go to MEM_WB.
- MEM_WB: RegWrite=1, MemtoReg=1, RegDst=0 -> FETCH.
- MEM_WRITE: MemWrite=1, IorD=1. MemWrite stays high until mem_listo=1, then go to FETCH.
- EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUOp=10 -> R_COMPL.
- R_COMPL: RegWrite=1, RegDst=1, MemtoReg=0 -> FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01 -> FETCH.
- JUMP: PCWrite=1, PCSource=10 -> FETCH.
- ADDI_EXEC: ALUSrcA=1, ALUSrcB=10, ALUOp=00 -> ADDI_WB.
- ADDI_WB: RegWrite=1, RegDst=0, MemtoReg=0 -> FETCH.
- Unused encodings 12-15: all outputs 0; next state FETCH.
- Latency with mem_listo tied to 1, counted in cycles from FETCH to the next FETCH: beq=3, j=3, R-type=4, addi=4, sw=4, lw=5. Each wait cycle adds one.
- MemRead and MemWrite are never high in the same cycle. RegWrite is never high in the same cycle as PCWrite.

Test Plan:
- Reset: hold reset=1 for 3 cycles with mem_listo=1 -> all outputs 0; one edge after release, estado=0 with MemRead=1 and PCWrite=1.
- R-type (opcode=000000, mem_listo=1): estado sequence 0,1,6,7,0; ALUOp=10 only in state 6; RegWrite=1 with RegDst=1 only in state 7.
- lw with wait states (opcode=100011, mem_listo=0 for 2 cycles in FETCH and in MEM_READ): sequence 0,0,0,1,2,3,3,3,4,0; IRWrite pulses exactly once; MemtoReg=1 in state 4.
- beq / j: beq gives 0,1,8,0 with ALUOp=01, PCWriteCond=1, PCSource=01 in state 8; j gives 0,1,9,0 with PCWrite=1, PCSource=10.
- Illegal opcode 6'b111111 -> sequence 0,1,0; opcode_invalido=1 only in the DECODE cycle; RegWrite and MemWrite stay 0 throughout.
- Reset asserted during MEM_WRITE with mem_listo=0 -> MemWrite=0 in the same cycle; FETCH after release; no store completes.
